// File: rtl/mem_arbiter_pkg.sv
// Shared types and constants for the IF/LS memory arbiter.
package mem_arbiter_pkg;

  // Arbiter FSM states.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  // Owner of the current / last transaction.
  typedef enum logic {
    OWN_IF = 1'b0,
    OWN_LS = 1'b1
  } owner_e;

  // RISC-V func3 access size codes. Code 3'd7 is not a legal access.
  localparam logic [2:0] F3_LB  = 3'd0;
  localparam logic [2:0] F3_LH  = 3'd1;
  localparam logic [2:0] F3_LW  = 3'd2;
  localparam logic [2:0] F3_LD  = 3'd3;
  localparam logic [2:0] F3_LBU = 3'd4;
  localparam logic [2:0] F3_LHU = 3'd5;
  localparam logic [2:0] F3_LWU = 3'd6;

  // Maximum number of WAIT cycles before a transaction is aborted.
  localparam int TIMEOUT_DEFAULT = 16;

  // True when an access of the given size is misaligned or the size is illegal.
  function automatic logic access_bad(input logic [2:0] size, input logic [2:0] addr_lo);
    logic bad;
    bad = 1'b1;
    case (size)
      F3_LB, F3_LBU: bad = 1'b0;
      F3_LH, F3_LHU: bad = addr_lo[0];
      F3_LW, F3_LWU: bad = |addr_lo[1:0];
      F3_LD:         bad = |addr_lo;
      default:       bad = 1'b1;
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/mem_arbiter_timeout_ctr.sv
// WAIT-cycle counter: cleared outside WAIT, counts while enabled and flags
// the last permitted WAIT cycle so the FSM can abort on the following edge.
module mem_timeout_ctr
  import mem_arbiter_pkg::*;
#(
  parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear_i,
  input  logic en_i,
  output logic expired_o
);

  localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Expired while sitting on the final WAIT cycle (count TIMEOUT-1).
  assign expired_o = (cnt_q == LAST);

  // Next count: clear wins, otherwise count up and saturate at LAST.
  always_comb begin
    cnt_d = cnt_q;
    if (clear_i) begin
      cnt_d = '0;
    end else if (en_i && !expired_o) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // Count register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Arbiter sharing one single-port memory between instruction fetch (IF)
// and load/store (LS).
//
// Handshake: a requester raises req with stable operands and holds them until
// its gnt pulses (one cycle, the ISSUE cycle), then drops req the cycle after.
// Completion is a one-cycle rvalid (with err on abort). On the memory side
// mem_req stays high with stable fields through ISSUE/WAIT until mem_ack is
// seen; mem_ack at any other time is ignored.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int ADDR_W  = 64,
  parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
  input  logic              clk,
  input  logic              reset,
  // instruction fetch
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_gnt,
  output logic              if_rvalid,
  output logic [31:0]       if_rdata,
  // load/store
  input  logic              ls_req,
  input  logic              ls_we,
  input  logic [2:0]        ls_size,
  input  logic [ADDR_W-1:0] ls_addr,
  input  logic [63:0]       ls_wdata,
  output logic              ls_gnt,
  output logic              ls_rvalid,
  output logic [63:0]       ls_rdata,
  // memory
  output logic              mem_req,
  output logic              mem_we,
  output logic [2:0]        mem_size,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [63:0]       mem_wdata,
  input  logic              mem_ack,
  input  logic [63:0]       mem_rdata,
  // status
  output logic              busy,
  output logic              err,
  output state_e            dbg_state_o
);

  state_e              state_q, state_d;
  owner_e              owner_q, owner_d;
  owner_e              last_owner_q, last_owner_d;
  logic                we_q, we_d;
  logic [2:0]          size_q, size_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [63:0]         wdata_q, wdata_d;
  logic                bad_q, bad_d;
  logic                err_q, err_d;
  logic [31:0]         if_rdata_q, if_rdata_d;
  logic [63:0]         ls_rdata_q, ls_rdata_d;

  logic                win_ls;
  logic                ctr_clear, ctr_en, ctr_expired;
  logic                done_ok, done_abort;

  mem_timeout_ctr #(.TIMEOUT(TIMEOUT)) u_timeout_ctr (
    .clk       (clk),
    .rst_n     (reset),
    .clear_i   (ctr_clear),
    .en_i      (ctr_en),
    .expired_o (ctr_expired)
  );

  // LS wins if it is alone, or on a tie when IF was granted last.
  assign win_ls = ls_req && (!if_req || (last_owner_q == OWN_IF));

  // Next-state, operand latch and read-data capture.
  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    last_owner_d = last_owner_q;
    we_d         = we_q;
    size_d       = size_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    bad_d        = bad_q;
    err_d        = err_q;
    if_rdata_d   = if_rdata_q;
    ls_rdata_d   = ls_rdata_q;
    ctr_clear    = 1'b1;
    ctr_en       = 1'b0;
    done_ok      = 1'b0;
    done_abort   = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (if_req || ls_req) begin
          state_d = ST_ISSUE;
          err_d   = 1'b0;
          if (win_ls) begin
            owner_d      = OWN_LS;
            last_owner_d = OWN_LS;
            we_d         = ls_we;
            size_d       = ls_size;
            addr_d       = ls_addr;
            wdata_d      = ls_wdata;
            bad_d        = access_bad(ls_size, ls_addr[2:0]);
          end else begin
            owner_d      = OWN_IF;
            last_owner_d = OWN_IF;
            we_d         = 1'b0;
            size_d       = F3_LW;
            addr_d       = if_addr;
            wdata_d      = '0;
            bad_d        = access_bad(F3_LW, if_addr[2:0]);
          end
        end
      end
      ST_ISSUE: begin
        if (bad_q) begin
          done_abort = 1'b1;
        end else if (mem_ack) begin
          done_ok = 1'b1;
        end else begin
          state_d = ST_WAIT;
        end
      end
      ST_WAIT: begin
        ctr_clear = 1'b0;
        ctr_en    = 1'b1;
        if (mem_ack) begin
          done_ok = 1'b1;
        end else if (ctr_expired) begin
          done_abort = 1'b1;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
    endcase

    // Completion: the owner's rdata takes the memory data, or zero on abort.
    if (done_ok || done_abort) begin
      state_d = ST_DONE;
      err_d   = done_abort;
      if (owner_q == OWN_LS) begin
        ls_rdata_d = done_ok ? mem_rdata : 64'd0;
      end else begin
        if_rdata_d = done_ok ? mem_rdata[31:0] : 32'd0;
      end
    end
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= ST_IDLE;
      owner_q      <= OWN_IF;
      last_owner_q <= OWN_IF;
      we_q         <= 1'b0;
      size_q       <= 3'd0;
      addr_q       <= '0;
      wdata_q      <= '0;
      bad_q        <= 1'b0;
      err_q        <= 1'b0;
      if_rdata_q   <= '0;
      ls_rdata_q   <= '0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      last_owner_q <= last_owner_d;
      we_q         <= we_d;
      size_q       <= size_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      bad_q        <= bad_d;
      err_q        <= err_d;
      if_rdata_q   <= if_rdata_d;
      ls_rdata_q   <= ls_rdata_d;
    end
  end

  // Outputs decode from registered state, so reset clears them immediately.
  assign busy        = (state_q != ST_IDLE);
  assign mem_req     = ((state_q == ST_ISSUE) && !bad_q) || (state_q == ST_WAIT);
  assign if_gnt      = (state_q == ST_ISSUE) && (owner_q == OWN_IF);
  assign ls_gnt      = (state_q == ST_ISSUE) && (owner_q == OWN_LS);
  assign if_rvalid   = (state_q == ST_DONE) && (owner_q == OWN_IF);
  assign ls_rvalid   = (state_q == ST_DONE) && (owner_q == OWN_LS);
  assign err         = (state_q == ST_DONE) && err_q;
  assign mem_we      = we_q;
  assign mem_size    = size_q;
  assign mem_addr    = addr_q;
  assign mem_wdata   = wdata_q;
  assign if_rdata    = if_rdata_q;
  assign ls_rdata    = ls_rdata_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: reset, IF read, arbitration, store with
// late ack, misalignment table, timeout and reset during WAIT.
module tb_mem_arbiter;
  import mem_arbiter_pkg::*;

  localparam int ADDR_W = 64;

  // clock / reset
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic              if_gnt, if_rvalid;
  logic [31:0]       if_rdata;
  logic              ls_req, ls_we;
  logic [2:0]        ls_size;
  logic [ADDR_W-1:0] ls_addr;
  logic [63:0]       ls_wdata;
  logic              ls_gnt, ls_rvalid;
  logic [63:0]       ls_rdata;
  logic              mem_req, mem_we;
  logic [2:0]        mem_size;
  logic [ADDR_W-1:0] mem_addr;
  logic [63:0]       mem_wdata;
  logic              mem_ack;
  logic [63:0]       mem_rdata;
  logic              busy, err;
  state_e            dbg_state;

  int checks   = 0;
  int failures = 0;

  // misalignment table: size, address, expected abort
  logic [2:0]  t_size [6] = '{F3_LW, F3_LD, F3_LH, 3'd7, F3_LHU, F3_LB};
  logic [63:0] t_addr [6] = '{64'h102, 64'h204, 64'h101, 64'h100, 64'h102, 64'h103};
  logic        t_bad  [6] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};

  mem_arbiter #(.ADDR_W(ADDR_W), .TIMEOUT(16)) dut (
    .clk         (clk),
    .reset       (reset),
    .if_req      (if_req),
    .if_addr     (if_addr),
    .if_gnt      (if_gnt),
    .if_rvalid   (if_rvalid),
    .if_rdata    (if_rdata),
    .ls_req      (ls_req),
    .ls_we       (ls_we),
    .ls_size     (ls_size),
    .ls_addr     (ls_addr),
    .ls_wdata    (ls_wdata),
    .ls_gnt      (ls_gnt),
    .ls_rvalid   (ls_rvalid),
    .ls_rdata    (ls_rdata),
    .mem_req     (mem_req),
    .mem_we      (mem_we),
    .mem_size    (mem_size),
    .mem_addr    (mem_addr),
    .mem_wdata   (mem_wdata),
    .mem_ack     (mem_ack),
    .mem_rdata   (mem_rdata),
    .busy        (busy),
    .err         (err),
    .dbg_state_o (dbg_state)
  );

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    reset = 1'b0;
    #2;
    tick();
    reset = 1'b1;
  endtask

  // scoreboard checks
  task automatic chk1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0b expected=%0b", tag, obs, exp);
    end
  endtask

  task automatic chk64(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    reset = 1'b0;
    if_req = 1'b0; if_addr = '0;
    ls_req = 1'b0; ls_we = 1'b0; ls_size = 3'd0; ls_addr = '0; ls_wdata = '0;
    mem_ack = 1'b0; mem_rdata = '0;

    // ---- reset state ----
    #3;
    chk1("rst_mem_req", mem_req, 1'b0);
    chk1("rst_busy", busy, 1'b0);
    chk1("rst_if_gnt", if_gnt, 1'b0);
    chk1("rst_ls_gnt", ls_gnt, 1'b0);
    chk1("rst_err", err, 1'b0);
    chk1("rst_if_rvalid", if_rvalid, 1'b0);
    chk1("rst_ls_rvalid", ls_rvalid, 1'b0);
    chk64("rst_if_rdata", 64'(if_rdata), 64'h0);
    chk64("rst_ls_rdata", ls_rdata, 64'h0);
    tick();
    tick();
    reset = 1'b1;

    // ---- IF read with ack in ISSUE ----
    if_req = 1'b1; if_addr = 64'h100;
    tick();
    chk1("if_rd_gnt", if_gnt, 1'b1);
    chk1("if_rd_ls_gnt", ls_gnt, 1'b0);
    chk1("if_rd_mem_req", mem_req, 1'b1);
    chk64("if_rd_addr", mem_addr, 64'h100);
    chk1("if_rd_we", mem_we, 1'b0);
    chk64("if_rd_size", 64'(mem_size), 64'h2);
    chk1("if_rd_busy", busy, 1'b1);
    if_req = 1'b0; if_addr = '0;
    mem_ack = 1'b1; mem_rdata = 64'hDEADBEEF_12345678;
    tick();
    chk1("if_rd_rvalid", if_rvalid, 1'b1);
    chk64("if_rd_rdata", 64'(if_rdata), 64'h12345678);
    chk1("if_rd_err", err, 1'b0);
    chk1("if_rd_mem_req_done", mem_req, 1'b0);
    chk1("if_rd_gnt_done", if_gnt, 1'b0);
    mem_ack = 1'b0;
    tick();
    chk64("if_rd_idle", 64'(dbg_state), 64'(ST_IDLE));
    chk1("if_rd_busy_idle", busy, 1'b0);
    chk1("if_rd_rvalid_idle", if_rvalid, 1'b0);
    chk64("if_rd_rdata_hold", 64'(if_rdata), 64'h12345678);

    // ---- arbitration: both requesting from reset, ack held high ----
    apply_reset();
    if_req = 1'b1; if_addr = 64'h300;
    ls_req = 1'b1; ls_we = 1'b0; ls_size = F3_LD; ls_addr = 64'h200;
    mem_ack = 1'b1; mem_rdata = 64'h11112222_33334444;
    tick();
    chk1("arb1_ls_gnt", ls_gnt, 1'b1);
    chk1("arb1_if_gnt", if_gnt, 1'b0);
    chk64("arb1_addr", mem_addr, 64'h200);
    chk64("arb1_size", 64'(mem_size), 64'h3);
    tick();
    chk1("arb1_ls_rvalid", ls_rvalid, 1'b1);
    chk1("arb1_if_rvalid", if_rvalid, 1'b0);
    chk64("arb1_ls_rdata", ls_rdata, 64'h11112222_33334444);
    tick();
    chk64("arb1_idle", 64'(dbg_state), 64'(ST_IDLE));
    chk1("arb1_idle_gnt", ls_gnt | if_gnt, 1'b0);
    mem_rdata = 64'h55556666_77778888;
    tick();
    chk1("arb2_if_gnt", if_gnt, 1'b1);
    chk1("arb2_ls_gnt", ls_gnt, 1'b0);
    chk64("arb2_addr", mem_addr, 64'h300);
    chk64("arb2_size", 64'(mem_size), 64'h2);
    tick();
    chk1("arb2_if_rvalid", if_rvalid, 1'b1);
    chk64("arb2_if_rdata", 64'(if_rdata), 64'h77778888);
    chk64("arb2_ls_rdata_hold", ls_rdata, 64'h11112222_33334444);
    tick();
    tick();
    chk1("arb3_ls_gnt", ls_gnt, 1'b1);
    chk1("arb3_if_gnt", if_gnt, 1'b0);
    if_req = 1'b0; ls_req = 1'b0;
    tick();
    chk1("arb3_ls_rvalid", ls_rvalid, 1'b1);
    chk64("arb3_ls_rdata", ls_rdata, 64'h55556666_77778888);
    chk64("arb3_if_rdata_hold", 64'(if_rdata), 64'h77778888);
    tick();
    mem_ack = 1'b0;

    // ---- LS store, ack three cycles after grant ----
    ls_req = 1'b1; ls_we = 1'b1; ls_size = F3_LD; ls_addr = 64'h208;
    ls_wdata = 64'hA5A5A5A5_A5A5A5A5; mem_rdata = 64'hCAFE0000_CAFE0000;
    tick();
    chk1("st_gnt", ls_gnt, 1'b1);
    chk1("st_mem_req", mem_req, 1'b1);
    chk1("st_we", mem_we, 1'b1);
    chk64("st_size", 64'(mem_size), 64'h3);
    chk64("st_addr", mem_addr, 64'h208);
    chk64("st_wdata", mem_wdata, 64'hA5A5A5A5_A5A5A5A5);
    ls_req = 1'b0; ls_we = 1'b0; ls_addr = 64'hFFF; ls_wdata = '0;
    tick();
    chk1("st_w1_mem_req", mem_req, 1'b1);
    chk1("st_w1_gnt", ls_gnt, 1'b0);
    chk64("st_w1_addr", mem_addr, 64'h208);
    chk1("st_w1_we", mem_we, 1'b1);
    chk64("st_w1_state", 64'(dbg_state), 64'(ST_WAIT));
    tick();
    chk1("st_w2_mem_req", mem_req, 1'b1);
    chk64("st_w2_wdata", mem_wdata, 64'hA5A5A5A5_A5A5A5A5);
    tick();
    chk1("st_w3_mem_req", mem_req, 1'b1);
    chk1("st_w3_rvalid", ls_rvalid, 1'b0);
    mem_ack = 1'b1;
    tick();
    mem_ack = 1'b0;
    chk1("st_rvalid", ls_rvalid, 1'b1);
    chk1("st_err", err, 1'b0);
    chk1("st_mem_req_done", mem_req, 1'b0);
    tick();
    chk1("st_busy_idle", busy, 1'b0);

    // ---- misalignment / invalid size table, ack held high ----
    mem_ack = 1'b1; mem_rdata = 64'h01234567_89ABCDEF;
    for (int i = 0; i < 6; i++) begin
      ls_req = 1'b1; ls_we = 1'b0; ls_size = t_size[i]; ls_addr = t_addr[i];
      tick();
      chk1($sformatf("mis%0d_gnt", i), ls_gnt, 1'b1);
      chk1($sformatf("mis%0d_mem_req", i), mem_req, !t_bad[i]);
      ls_req = 1'b0;
      tick();
      chk1($sformatf("mis%0d_rvalid", i), ls_rvalid, 1'b1);
      chk1($sformatf("mis%0d_err", i), err, t_bad[i]);
      chk64($sformatf("mis%0d_rdata", i), ls_rdata, t_bad[i] ? 64'h0 : 64'h01234567_89ABCDEF);
      tick();
      chk1($sformatf("mis%0d_err_idle", i), err, 1'b0);
    end
    mem_ack = 1'b0;

    // ---- timeout: no ack for an IF read ----
    if_req = 1'b1; if_addr = 64'h400;
    tick();
    chk1("to_gnt", if_gnt, 1'b1);
    if_req = 1'b0;
    for (int i = 1; i <= 16; i++) begin
      tick();
      chk1($sformatf("to_wait%0d_mem_req", i), mem_req, 1'b1);
      chk1($sformatf("to_wait%0d_rvalid", i), if_rvalid, 1'b0);
    end
    tick();
    chk1("to_mem_req_low", mem_req, 1'b0);
    chk1("to_rvalid", if_rvalid, 1'b1);
    chk1("to_err", err, 1'b1);
    chk64("to_rdata", 64'(if_rdata), 64'h0);
    tick();
    chk64("to_idle", 64'(dbg_state), 64'(ST_IDLE));
    chk1("to_err_idle", err, 1'b0);

    // ---- reset asserted during WAIT ----
    ls_req = 1'b1; ls_we = 1'b0; ls_size = F3_LD; ls_addr = 64'h300;
    tick();
    ls_req = 1'b0;
    tick();
    tick();
    chk1("rw_mem_req_before", mem_req, 1'b1);
    #2;
    reset = 1'b0;
    #1;
    chk1("rw_mem_req", mem_req, 1'b0);
    chk1("rw_busy", busy, 1'b0);
    chk1("rw_ls_gnt", ls_gnt, 1'b0);
    chk1("rw_if_gnt", if_gnt, 1'b0);
    chk64("rw_ls_rdata", ls_rdata, 64'h0);
    tick();
    reset = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk1($sformatf("rw_post%0d_rvalid", i), ls_rvalid, 1'b0);
      chk1($sformatf("rw_post%0d_busy", i), busy, 1'b0);
    end

    // final report
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, default 64, byte-address width.
REQ-002 SHALL have parameter TIMEOUT, default 16, maximum number of WAIT cycles before abort.
REQ-003 SHALL have ports: clk input 1, the single clock; reset input 1, asynchronous, active-low.
REQ-004 SHALL have instruction-fetch ports: if_req input 1; if_addr input ADDR_W; if_gnt output 1; if_rvalid output 1; if_rdata output 32.
REQ-005 SHALL have load/store ports: ls_req input 1; ls_we input 1; ls_size input 3 (func3 encoding); ls_addr input ADDR_W; ls_wdata input 64; ls_gnt output 1; ls_rvalid output 1; ls_rdata output 64.
REQ-006 SHALL have memory ports: mem_req output 1; mem_we output 1; mem_size output 3; mem_addr output ADDR_W; mem_wdata output 64; mem_ack input 1; mem_rdata input 64.
REQ-007 SHALL have status ports: busy output 1, state != IDLE; err output 1, one-cycle pulse with rvalid on an aborted transaction.

Function
REQ-008 SHALL share one single-port memory between IF and LS using FSM states IDLE, ISSUE, WAIT, DONE.
REQ-009 In IDLE, with any req high, SHALL latch the winner's address, write enable, size and wdata, then move to ISSUE at the next edge.
REQ-010 Winner selection: one requester pending -> it wins; both pending -> the one not granted last; last_owner resets to IF, so LS wins the first tie.
REQ-011 SHALL pulse the winner's gnt for exactly the ISSUE cycle; the requester holds req and operands stable until gnt and deasserts req in the cycle after gnt.
REQ-012 SHALL drive mem_req high, with latched fields on mem_*, throughout ISSUE and WAIT.
REQ-013 IF transactions SHALL drive mem_we=0 and mem_size=3'b010.
REQ-014 mem_ack sampled in ISSUE SHALL go to DONE; otherwise the FSM goes to WAIT.
REQ-015 mem_ack sampled in WAIT SHALL go to DONE.
REQ-016 After TIMEOUT cycles in WAIT without ack, SHALL go to DONE with err.
REQ-017 On ack, SHALL register mem_rdata into the owner's rdata (IF: bits [31:0]); on timeout, rdata=0.
REQ-018 In DONE, SHALL pulse the owner's rvalid for one cycle (also for writes, as completion), then go to IDLE.
REQ-019 Minimum latency: req at cycle N -> gnt/mem_req at N+1 -> ack at N+1 -> rvalid at N+2 -> next grant at N+4.
REQ-020 LS misalignment check in IDLE: LH/LHU needs addr[0]=0; LW/LWU/IF needs addr[1:0]=0; LD needs addr[2:0]=0; size 7 is invalid.
REQ-021 A misaligned or invalid request SHALL be granted (ISSUE, gnt pulse) with mem_req held low, then go straight to DONE with err and rdata=0.
REQ-022 A req held high in IDLE after DONE SHALL be treated as a new request.
REQ-023 Non-owner rdata SHALL hold its last value.
REQ-024 mem_ack outside ISSUE/WAIT SHALL be ignored.

Reset
REQ-025 While reset=0, SHALL force state=IDLE, last_owner=IF, timeout counter=0, and all outputs 0 (mem_req, gnt, rvalid, rdata, err, busy), independent of clk.
REQ-026 Reset mid-transaction SHALL drop mem_req immediately, with no rvalid for the abandoned transaction; the memory tolerates abandonment.

Structure
REQ-027 The shared package SHALL hold the FSM state enum, the func3 size codes (LB..LWU), the owner encoding and the TIMEOUT default.
REQ-028 The wait counter SHALL be a sub-module, mem_timeout_ctr: clear, enable, expired output.

Verification
REQ-029 Scenario: IF-only read at 0x100, mem_ack in the ISSUE cycle, mem_rdata=0xDEADBEEF_12345678 -> if_gnt at N+1, if_rvalid at N+2, if_rdata=0x12345678.
REQ-030 Scenario: IF and LS both requesting from reset -> LS granted first, then IF; with both still requesting, grants alternate LS, IF, LS.
REQ-031 Scenario: LS store, LD at 0x208, wdata=0xA5A5... -> mem_we=1, mem_size=3, mem_addr=0x208 held until ack arrives 3 cycles later; ls_rvalid follows the DONE cycle.
REQ-032 Scenario: LS LW at 0x102 -> ls_gnt pulse, no mem_req, ls_rvalid with err=1 and ls_rdata=0.
REQ-033 Scenario: no mem_ack with TIMEOUT=16 -> mem_req low after 16 WAIT cycles; rvalid and err pulse; FSM back in IDLE.
REQ-034 Scenario: reset=0 asserted during WAIT -> mem_req, busy and gnt are 0 before the next clk edge; no rvalid follows.
